ps2_key_fifo: RTL and testbench
===============================

# ps2_key_fifo

Parametrised PS/2 keyboard receiver that replaces the single-byte ps2 receiver. It filters and synchronises the PS/2 lines, deframes 11-bit device-to-host frames and checks odd parity. It folds the E0 (extended) and F0 (break) prefixes into per-key flags and queues decoded key events in a first-word-fall-through FIFO. It sits between the PS/2 pins and the display/transcoder logic, which pops events at its own rate.

## Interface
- FILTER_LEN, 8: number of consecutive equal synchronised ps2c samples required to change filtered clock level (≥2)
- FIFO_DEPTH, 8: key-event FIFO depth, power of 2, ≥2
- TIMEOUT_CYCLES, 50000: clock cycles without a filtered ps2c falling edge after which a partial frame is aborted
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- ps2d  in  1  raw PS/2 data pin
- ps2c  in  1  raw PS/2 clock pin
- rd_en  in  1  pop head entry; ignored when fifo_empty
- err_clr  in  1  clears sticky overflow
- key_code  out  8  head entry scan code; 0 when empty
- key_ext  out  1  head entry preceded by E0; 0 when empty
- key_break  out  1  head entry preceded by F0 (release); 0 when empty
- fifo_empty  out  1  no entries
- fifo_full  out  1  FIFO_DEPTH entries
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- frame_err  out  1  one-cycle pulse: parity error, stop bit 0, or timeout
- overflow  out  1  sticky: a decoded event was dropped because FIFO full

## Operation
- ps2c and ps2d each pass through a 2-FF synchroniser. Filtered ps2c updates only when the last FILTER_LEN synchronised samples agree. A falling edge of the filtered clock is a sample strobe; ps2d is taken from its synchronised value at the strobe.
- Frame FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
  - IDLE: a strobe with ps2d=0 starts a frame; ps2d=1 is ignored.
  - STOP: accepts the byte only if odd parity over data+parity holds and the stop bit is 1. Otherwise pulse frame_err, discard the byte and clear both prefix flags.
- Timeout: in any state other than IDLE, a counter reloads on each strobe. Reaching TIMEOUT_CYCLES forces IDLE, pulses frame_err and clears the prefix flags.
- Decoder on each accepted byte:
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - Repeated prefixes are idempotent.
- FIFO push when full: entry dropped, overflow set, count unchanged. Push and valid pop in the same cycle when full: both happen, count unchanged. rd_en when empty is ignored, including a same-cycle push.
- err_clr clears overflow. If err_clr coincides with a new drop, overflow stays 1.
- Reset at any point: FSM to IDLE, flags, counters and FIFO cleared. An interrupted frame is lost, and the bench restarts framing on the next start bit.

## Timing
- Reset values: key_code 0, key_ext 0, key_break 0, fifo_empty 1, fifo_full 0, fifo_count 0, frame_err 0, overflow 0.
- Strobe occurs FILTER_LEN+2 cycles after the raw ps2c falling transition, provided ps2c stays low through the filter.
- Stop-bit strobe at cycle N: frame_err pulses at N+1, or the FIFO is written at N+1. key_* valid and fifo_empty=0 from N+2.
- Pop: rd_en high at edge K; the next entry, or zeros/empty, is on the outputs after edge K. fifo_count updates at the same edge.
- Minimum supported PS/2 bit period: 4·(FILTER_LEN+2) cycles.

## Test plan
- Frame 0x1C (parity 0, stop 1), bit period 200 cycles -> one entry {ext 0, brk 0, 1C}, count 1; one rd_en pulse -> fifo_empty=1, key_code 0.
- Bytes F0,1C then E0,F0,75 -> two entries {0,1,1C} and {1,1,75}; prefix bytes are never queued.
- Frame 0x1C with parity 1 -> frame_err single-cycle pulse, count 0. Then F0, a bad-stop frame, then 1C -> entry {0,0,1C}, because the error cleared brk.
- FIFO_DEPTH=4: send 16,1E,26,25,2E with no reads -> full=1, count 4, overflow=1.
  - Reads return 16,1E,26,25.
  - err_clr -> overflow=0.
  - Push+pop while full keeps count 4.
- TIMEOUT_CYCLES=1000: start bit + 3 data bits, then ps2c held high 1002 cycles -> frame_err pulse, FSM IDLE; the next full 0x1C frame is received correctly.
- ps2c low glitch of FILTER_LEN-1 cycles in IDLE -> no strobe, no state change. reset asserted mid-frame -> all outputs at reset values; the following frame 0x29 is queued as {0,0,29}.

Source files
------------

// File: rtl/ps2_key_fifo_if.sv
// Key-event read side of ps2_key_fifo: the consumer (master) pops decoded events
// and clears the sticky overflow; the receiver (slave) presents the FIFO head and status.
interface ps2_key_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          err_clr;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_break;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          overflow;

    modport master (
        output rd_en, err_clr,
        input  key_code, key_ext, key_break, fifo_empty, fifo_full, fifo_count,
        input  frame_err, overflow
    );

    modport slave (
        input  rd_en, err_clr,
        output key_code, key_ext, key_break, fifo_empty, fifo_full, fifo_count,
        output frame_err, overflow
    );
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: glitch-filtered clock, 11-bit frame deframer with odd parity,
// E0/F0 prefix folding and a first-word-fall-through queue of key events.
module ps2_key_fifo #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2d,
    input  logic          ps2c,
    ps2_key_fifo_if.slave evt
);
    localparam int unsigned FW = $clog2(FILTER_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Synchronisers idle high, matching the released PS/2 bus.
    logic [1:0] c_sync_q, d_sync_q;
    logic       c_s, d_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c};
            d_sync_q <= {d_sync_q[0], ps2d};
        end
    end

    assign c_s = c_sync_q[1];
    assign d_s = d_sync_q[1];

    // fcnt_q counts consecutive samples that disagree with the filtered level.
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          strobe;

    assign strobe = filt_q & ~c_s & (fcnt_q == FW'(FILTER_LEN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (c_s == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= c_s;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FW'(1);
        end
    end

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_vld_q, byte_vld_d;
    logic          byte_err_q, byte_err_d;
    logic          timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_vld_q <= 1'b0;
            byte_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_vld_q <= byte_vld_d;
            byte_err_q <= byte_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = '0;
        byte_vld_d = 1'b0;
        byte_err_d = 1'b0;
        timeout    = (state_q != StIdle) && !strobe && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

        if (state_q != StIdle) begin
            to_cnt_d = strobe ? '0 : to_cnt_q + TW'(1);
        end

        if (timeout) begin
            state_d    = StIdle;
            byte_err_d = 1'b1;
        end else if (strobe) begin
            case (state_q)
                StIdle: begin
                    if (!d_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {d_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = d_s;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (d_s && (^{shift_q, par_q})) byte_vld_d = 1'b1;
                    else                            byte_err_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Prefix decode and FIFO bookkeeping act one cycle after the stop strobe.
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, wr, drop, full, empty;
    logic [9:0]    head;

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (byte_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

        empty   = (count_q == '0);
        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = evt.rd_en & ~empty;
        wr      = push & (~full | pop);
        drop    = push & full & ~pop;
        count_d = count_q + CW'(wr) - CW'(pop);
        ovf_d   = drop | (ovf_q & ~evt.err_clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            wr_ptr_q <= wr_ptr_q + AW'(wr);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem[wr_ptr_q] <= {ext_q, brk_q, shift_q};
    end

    assign head           = empty ? 10'd0 : mem[rd_ptr_q];
    assign evt.key_code   = head[7:0];
    assign evt.key_break  = head[8];
    assign evt.key_ext    = head[9];
    assign evt.fifo_empty = empty;
    assign evt.fifo_full  = full;
    assign evt.fifo_count = count_q;
    assign evt.frame_err  = byte_err_q;
    assign evt.overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed plus randomised bench for ps2_key_fifo; expected events come from a queue model
// that applies the prefix, error and overflow rules to each byte the bench transmits.
module tb_ps2_key_fifo;
    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned FIFO_DEPTH     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 1000;
    localparam int          HALF           = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2d  = 1'b1;
    logic ps2c  = 1'b1;

    ps2_key_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) evt ();

    ps2_key_fifo #(
        .FILTER_LEN    (FILTER_LEN),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2d (ps2d),
        .ps2c (ps2c),
        .evt  (evt)
    );

    always #5 clock = ~clock;

    logic [9:0] q[$];
    bit         m_ext, m_brk, m_ovf;
    int         n_chk, n_fail;
    int         err_cnt, err_run;
    bit         err_long;

    always @(negedge clock) begin
        if (evt.frame_err === 1'b1) begin
            err_cnt++;
            err_run++;
            if (err_run > 1) err_long = 1'b1;
        end else begin
            err_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par,
                                          input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half,
                             input bit pop_at_stop);
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            tick(half);
            ps2c = 1'b0;
            if (pop_at_stop && i == 10) begin
                // Land rd_en on the edge that writes the stop-bit byte.
                tick(FILTER_LEN + 2);
                evt.rd_en = 1'b1;
                tick(1);
                evt.rd_en = 1'b0;
                tick(half - FILTER_LEN - 3);
            end else begin
                tick(half);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int half, input bit pop_at_stop);
        int e0;
        int want_err;
        e0       = err_cnt;
        want_err = 0;
        send_bits(frame(b, bad_par, bad_stop), 11, half, pop_at_stop);
        tick(half);
        if (pop_at_stop && q.size() > 0) void'(q.pop_front());
        if (bad_par || bad_stop) begin
            m_ext    = 1'b0;
            m_brk    = 1'b0;
            want_err = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (q.size() == FIFO_DEPTH) m_ovf = 1'b1;
            else                        q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        chk($sformatf("frame_err_pulses_%02h", b), err_cnt - e0, want_err);
    endtask

    task automatic check_state(input string tag);
        logic [9:0] h;
        h = (q.size() > 0) ? q[0] : 10'd0;
        @(negedge clock);
        chk({tag, ":code"},  evt.key_code,   h[7:0]);
        chk({tag, ":brk"},   evt.key_break,  h[8]);
        chk({tag, ":ext"},   evt.key_ext,    h[9]);
        chk({tag, ":empty"}, evt.fifo_empty, q.size() == 0);
        chk({tag, ":full"},  evt.fifo_full,  q.size() == FIFO_DEPTH);
        chk({tag, ":count"}, evt.fifo_count, q.size());
        chk({tag, ":ovf"},   evt.overflow,   m_ovf);
        chk({tag, ":ferr"},  evt.frame_err,  0);
    endtask

    task automatic pop_one();
        evt.rd_en = 1'b1;
        tick(1);
        evt.rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        tick(3);
        q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        check_state(tag);
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        int e0;
        logic [7:0] code;
        evt.rd_en   = 1'b0;
        evt.err_clr = 1'b0;
        tick(1);
        do_reset("reset");
        tick(5);
        check_state("after_reset");

        // Single frame at 200-cycle bit period, then pop.
        send_byte(8'h1C, 0, 0, 100, 0);
        check_state("first_1c");
        pop_one();
        check_state("first_pop");

        // Prefix folding.
        send_byte(8'hF0, 0, 0, HALF, 0);
        send_byte(8'h1C, 0, 0, HALF, 0);
        send_byte(8'hE0, 0, 0, HALF, 0);
        send_byte(8'hF0, 0, 0, HALF, 0);
        send_byte(8'h75, 0, 0, HALF, 0);
        check_state("brk_1c");
        pop_one();
        check_state("ext_brk_75");
        pop_one();
        check_state("prefix_drained");

        // Parity error, then an errored frame clearing a pending break prefix.
        send_byte(8'h1C, 1, 0, HALF, 0);
        check_state("bad_parity");
        send_byte(8'hF0, 0, 0, HALF, 0);
        send_byte(8'h1C, 0, 1, HALF, 0);
        send_byte(8'h1C, 0, 0, HALF, 0);
        check_state("brk_cleared");
        pop_one();

        // Overflow, draining, err_clr, push+pop while full.
        send_byte(8'h16, 0, 0, HALF, 0);
        send_byte(8'h1E, 0, 0, HALF, 0);
        send_byte(8'h26, 0, 0, HALF, 0);
        send_byte(8'h25, 0, 0, HALF, 0);
        send_byte(8'h2E, 0, 0, HALF, 0);
        check_state("overflowed");
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check_state($sformatf("drain_%0d", i));
        end
        evt.err_clr = 1'b1;
        tick(1);
        evt.err_clr = 1'b0;
        m_ovf = 1'b0;
        check_state("err_clr");
        send_byte(8'h3C, 0, 0, HALF, 0);
        send_byte(8'h4B, 0, 0, HALF, 0);
        send_byte(8'h44, 0, 0, HALF, 0);
        send_byte(8'h4D, 0, 0, HALF, 0);
        check_state("refilled");
        send_byte(8'h5A, 0, 0, HALF, 1);
        check_state("push_pop_full");
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check_state($sformatf("drain2_%0d", i));
        end

        // rd_en on an empty FIFO coinciding with a push is ignored.
        send_byte(8'h45, 0, 0, HALF, 1);
        check_state("push_pop_empty");
        pop_one();

        // Timeout aborts a partial frame and clears a pending prefix.
        send_byte(8'hF0, 0, 0, HALF, 0);
        send_bits(frame(8'h1C, 0, 0), 4, HALF, 0);
        e0 = err_cnt;
        tick(TIMEOUT_CYCLES + 100);
        chk("timeout_err", err_cnt - e0, 1);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_byte(8'h1C, 0, 0, HALF, 0);
        check_state("after_timeout");
        pop_one();

        // Short clock glitch with data low must not start a frame.
        e0   = err_cnt;
        ps2d = 1'b0;
        ps2c = 1'b0;
        tick(FILTER_LEN - 1);
        ps2c = 1'b1;
        ps2d = 1'b1;
        tick(HALF);
        chk("glitch_err", err_cnt - e0, 0);
        check_state("glitch");
        send_byte(8'h1C, 0, 0, HALF, 0);
        check_state("after_glitch");

        // Reset mid-frame.
        send_byte(8'hF0, 0, 0, HALF, 0);
        send_bits(frame(8'h29, 0, 0), 5, HALF, 0);
        do_reset("mid_reset");
        tick(HALF);
        send_byte(8'h29, 0, 0, HALF, 0);
        check_state("after_reset_29");
        pop_one();

        // Randomised key events with occasional bad frames and reads.
        for (int it = 0; it < 10; it++) begin
            code = 8'($urandom_range(0, 255));
            if (code == 8'hE0 || code == 8'hF0) code = 8'h5A;
            if ($urandom_range(0, 1) == 1) send_byte(8'hE0, 0, 0, HALF, 0);
            if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 0, 0, HALF, 0);
            send_byte(code, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, HALF, 0);
            check_state($sformatf("rand_%0d", it));
            if ($urandom_range(0, 2) != 0) begin
                pop_one();
                check_state($sformatf("rand_pop_%0d", it));
            end
        end

        chk("frame_err_single_cycle", err_long, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
